datapath_bus: RTL and testbench

- 32-bit CPU datapath core with a register file (R0-R15), HI, LO, Y, a 64-bit Z, and an MDR, joined by a single multiplexed 32-bit bus.
- Contains a one-hot-controlled ALU whose result is captured in Z.
- Driven externally by the control unit's out/in strobes; the bench supplies clk from a free-running clock generator with a 20 ns period.

---
 rtl/datapath_bus.sv | 157 +++++++++++++++
 tb/tb_datapath_bus.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_bus.sv
// Single-bus CPU datapath: R0-R15, HI, LO, Y, 64-bit Z and MDR around a one-hot ALU.
// Latency: bus and ALU are combinational; register loads take one clk edge.
// Backpressure: none; strobes from the control unit are obeyed every cycle.
module datapath_bus #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
    input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             HIin, LOin, Yin, Zin, MDRin,
    input  logic [11:0]      ALUControl,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             MDRRead,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] R0MuxIn, R1MuxIn, R2MuxIn, R3MuxIn, R4MuxIn, R5MuxIn, R6MuxIn, R7MuxIn,
    output logic [WIDTH-1:0] R8MuxIn, R9MuxIn, R10MuxIn, R11MuxIn, R12MuxIn, R13MuxIn, R14MuxIn, R15MuxIn,
    output logic [WIDTH-1:0] HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn, MDRMuxIn,
    output logic [WIDTH-1:0] PCMuxIn, InPortMuxIn, CMuxIn,
    output logic [WIDTH-1:0] Yout
);

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } z_t;

    logic [15:0]        r_out_sel;
    logic [15:0]        r_in_en;
    logic [WIDTH-1:0]   r_q [16];
    logic [WIDTH-1:0]   hi_q, lo_q, y_q, mdr_q;
    z_t                 z_q;
    logic [WIDTH-1:0]   bus_dat;
    logic [2*WIDTH-1:0] alu_dat;

    assign r_out_sel = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                        R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_in_en   = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                        R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // Lowest priority first so later (higher-priority) selects override.
    always_comb begin
        bus_dat = '0;
        if (Cout)      bus_dat = '0;
        if (InPortout) bus_dat = '0;
        if (MDRout)    bus_dat = mdr_q;
        if (PCout)     bus_dat = '0;
        if (Zlowout)   bus_dat = z_q.lo;
        if (Zhighout)  bus_dat = z_q.hi;
        if (LOout)     bus_dat = lo_q;
        if (HIout)     bus_dat = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out_sel[i]) bus_dat = r_q[i];
        end
    end

    logic [4:0]                sh_amt;
    logic [5:0]                rol_amt;
    logic [WIDTH-1:0]          ror_dat, rol_dat;
    logic signed [2*WIDTH-1:0] prod_dat;
    logic signed [WIDTH-1:0]   a_s, b_s, quo_dat, rem_dat;

    assign sh_amt  = bus_dat[4:0];
    assign rol_amt = 6'd32 - {1'b0, sh_amt};
    assign ror_dat = WIDTH'({y_q, y_q} >> sh_amt);
    assign rol_dat = WIDTH'({y_q, y_q} >> rol_amt);
    assign a_s     = y_q;
    assign b_s     = bus_dat;
    assign prod_dat = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) *
                      $signed({{WIDTH{bus_dat[WIDTH-1]}}, bus_dat});

    // Divide by zero yields 0; the lone overflow case (MIN / -1) is pinned to MIN rem 0.
    always_comb begin
        quo_dat = '0;
        rem_dat = '0;
        if (b_s == '0) begin
            quo_dat = '0;
            rem_dat = '0;
        end else if (a_s == {1'b1, {(WIDTH-1){1'b0}}} && b_s == '1) begin
            quo_dat = a_s;
            rem_dat = '0;
        end else begin
            quo_dat = a_s / b_s;
            rem_dat = a_s % b_s;
        end
    end

    always_comb begin
        alu_dat = '0;
        case (ALUControl)
            12'h001: alu_dat = {{WIDTH{1'b0}}, y_q + bus_dat};
            12'h002: alu_dat = {{WIDTH{1'b0}}, y_q - bus_dat};
            12'h004: alu_dat = prod_dat;
            12'h008: alu_dat = {rem_dat, quo_dat};
            12'h010: alu_dat = {{WIDTH{1'b0}}, y_q >> sh_amt};
            12'h020: alu_dat = {{WIDTH{1'b0}}, y_q << sh_amt};
            12'h040: alu_dat = {{WIDTH{1'b0}}, ror_dat};
            12'h080: alu_dat = {{WIDTH{1'b0}}, rol_dat};
            12'h100: alu_dat = {{WIDTH{1'b0}}, y_q & bus_dat};
            12'h200: alu_dat = {{WIDTH{1'b0}}, y_q | bus_dat};
            12'h400: alu_dat = {{WIDTH{1'b0}}, -bus_dat};
            12'h800: alu_dat = {{WIDTH{1'b0}}, ~bus_dat};
            default: alu_dat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
            mdr_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_in_en[i]) r_q[i] <= bus_dat;
            end
            if (HIin)  hi_q  <= bus_dat;
            if (LOin)  lo_q  <= bus_dat;
            if (Yin)   y_q   <= bus_dat;
            if (Zin)   z_q   <= alu_dat;
            if (MDRin) mdr_q <= MDRRead ? Mdatain : bus_dat;
        end
    end

    assign BusMuxOut   = bus_dat;
    assign R0MuxIn     = r_q[0];
    assign R1MuxIn     = r_q[1];
    assign R2MuxIn     = r_q[2];
    assign R3MuxIn     = r_q[3];
    assign R4MuxIn     = r_q[4];
    assign R5MuxIn     = r_q[5];
    assign R6MuxIn     = r_q[6];
    assign R7MuxIn     = r_q[7];
    assign R8MuxIn     = r_q[8];
    assign R9MuxIn     = r_q[9];
    assign R10MuxIn    = r_q[10];
    assign R11MuxIn    = r_q[11];
    assign R12MuxIn    = r_q[12];
    assign R13MuxIn    = r_q[13];
    assign R14MuxIn    = r_q[14];
    assign R15MuxIn    = r_q[15];
    assign HIMuxIn     = hi_q;
    assign LOMuxIn     = lo_q;
    assign ZhighMuxIn  = z_q.hi;
    assign ZlowMuxIn   = z_q.lo;
    assign MDRMuxIn    = mdr_q;
    assign PCMuxIn     = '0;
    assign InPortMuxIn = '0;
    assign CMuxIn      = '0;
    assign Yout        = y_q;

endmodule

// File: tb/tb_datapath_bus.sv
// Bench for datapath_bus: scenario tasks with a queue of expected values popped at output time.
module tb_datapath_bus;

    logic        clk, clr;
    logic [15:0] rout, rin;
    logic        hi_out, lo_out, zh_out, zl_out, pc_out, mdr_out, inp_out, c_out;
    logic        hi_in, lo_in, y_in, z_in, mdr_in;
    logic [11:0] alu;
    logic [31:0] mdatain;
    logic        mdr_read;
    logic [31:0] bus;
    logic [31:0] rq [16];
    logic [31:0] hiq, loq, zhq, zlq, mdrq, pcq, inq, cq, yq;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q [$];
    logic [63:0] e;

    datapath_bus #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(hi_out), .LOout(lo_out), .Zhighout(zh_out), .Zlowout(zl_out),
        .PCout(pc_out), .MDRout(mdr_out), .InPortout(inp_out), .Cout(c_out),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(hi_in), .LOin(lo_in), .Yin(y_in), .Zin(z_in), .MDRin(mdr_in),
        .ALUControl(alu), .Mdatain(mdatain), .MDRRead(mdr_read),
        .BusMuxOut(bus),
        .R0MuxIn(rq[0]), .R1MuxIn(rq[1]), .R2MuxIn(rq[2]), .R3MuxIn(rq[3]),
        .R4MuxIn(rq[4]), .R5MuxIn(rq[5]), .R6MuxIn(rq[6]), .R7MuxIn(rq[7]),
        .R8MuxIn(rq[8]), .R9MuxIn(rq[9]), .R10MuxIn(rq[10]), .R11MuxIn(rq[11]),
        .R12MuxIn(rq[12]), .R13MuxIn(rq[13]), .R14MuxIn(rq[14]), .R15MuxIn(rq[15]),
        .HIMuxIn(hiq), .LOMuxIn(loq), .ZhighMuxIn(zhq), .ZlowMuxIn(zlq), .MDRMuxIn(mdrq),
        .PCMuxIn(pcq), .InPortMuxIn(inq), .CMuxIn(cq),
        .Yout(yq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        rout = '0; rin = '0;
        hi_out = 0; lo_out = 0; zh_out = 0; zl_out = 0;
        pc_out = 0; mdr_out = 0; inp_out = 0; c_out = 0;
        hi_in = 0; lo_in = 0; y_in = 0; z_in = 0; mdr_in = 0;
        alu = '0; mdr_read = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_mdr(input logic [31:0] v);
        mdatain = v; mdr_read = 1; mdr_in = 1;
        tick();
        idle();
    endtask

    task automatic load_reg(input int n, input logic [31:0] v);
        put_mdr(v);
        mdr_out = 1; rin[n] = 1;
        tick();
        idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        put_mdr(v);
        mdr_out = 1; y_in = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle();
        mdatain = 32'hDEADBEEF;
        #5 clr = 1'b0;
        rin = '1; hi_in = 1; lo_in = 1; y_in = 1; z_in = 1; mdr_in = 1;
        mdr_read = 1; alu = 12'h001;
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rq[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_r%0d: got %h expected 00000000", i, rq[i]);
            end
        end
        checks++;
        if ({hiq, loq, yq, mdrq} !== 128'h0) begin
            errors++;
            $display("FAIL reset_hi_lo_y_mdr: got %h %h %h %h expected zeros", hiq, loq, yq, mdrq);
        end
        checks++;
        if ({zhq, zlq} !== 64'h0) begin
            errors++;
            $display("FAIL reset_z: got %h%h expected 0", zhq, zlq);
        end
        checks++;
        if (bus !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 00000000", bus);
        end
        idle();
        clr = 1'b1;
        tick();
    endtask

    task automatic test_mdr_load();
        mdatain = 32'h23; mdr_read = 1; mdr_in = 1;
        exp_q.push_back(64'h23);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if ({32'h0, mdrq} !== e) begin
            errors++;
            $display("FAIL mdr_from_mem: got %h expected %h", mdrq, e[31:0]);
        end
        mdr_out = 1; rin[2] = 1;
        exp_q.push_back(64'h23);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if ({32'h0, rq[2]} !== e) begin
            errors++;
            $display("FAIL mdr_to_r2: got %h expected %h", rq[2], e[31:0]);
        end
    endtask

    task automatic test_shl();
        load_reg(4, 32'd3);
        rout[2] = 1; y_in = 1;
        exp_q.push_back(64'h23);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if ({32'h0, yq} !== e) begin
            errors++;
            $display("FAIL shl_y: got %h expected %h", yq, e[31:0]);
        end
        rout[4] = 1; alu = 12'h020; z_in = 1;
        exp_q.push_back(64'h118);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if ({zhq, zlq} !== e) begin
            errors++;
            $display("FAIL shl_z: got %h%h expected %h", zhq, zlq, e);
        end
        zl_out = 1; rin[5] = 1;
        exp_q.push_back(64'h118);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if ({32'h0, rq[5]} !== e) begin
            errors++;
            $display("FAIL shl_r5: got %h expected %h", rq[5], e[31:0]);
        end
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [11:0] op,
                          input logic [63:0] expv, input string nm);
        load_y(a);
        put_mdr(b);
        mdr_out = 1; alu = op; z_in = 1;
        exp_q.push_back(expv);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if ({zhq, zlq} !== e) begin
            errors++;
            $display("FAIL %s: got %h%h expected %h", nm, zhq, zlq, e);
        end
    endtask

    task automatic test_alu_ops();
        alu_op(32'hFFFFFFFE, 32'd3, 12'h004, 64'hFFFFFFFF_FFFFFFFA, "mul_neg");
        alu_op(32'd7, 32'd2, 12'h008, 64'h00000001_00000003, "div_pos");
        alu_op(32'hFFFFFFF9, 32'd2, 12'h008, 64'hFFFFFFFF_FFFFFFFD, "div_neg");
        alu_op(32'd5, 32'd0, 12'h008, 64'h0, "div_zero");
        alu_op(32'h80000001, 32'd1, 12'h080, 64'h3, "rol1");
        alu_op(32'h80000001, 32'd1, 12'h040, 64'hC0000000, "ror1");
        alu_op(32'h12345678, 32'd32, 12'h020, 64'h12345678, "shl32");
        alu_op(32'h12345678, 32'h40, 12'h080, 64'h12345678, "rol0");
        alu_op(32'h80000000, 32'd4, 12'h010, 64'h08000000, "shr4");
        alu_op(32'd3, 32'd5, 12'h002, 64'hFFFFFFFE, "sub_neg");
        alu_op(32'd9, 32'd5, 12'h400, 64'hFFFFFFFB, "neg");
        alu_op(32'd9, 32'h0F0F0F0F, 12'h800, 64'hF0F0F0F0, "not");
        alu_op(32'hFF00FF00, 32'h0FF00FF0, 12'h100, 64'h0F000F00, "and");
        alu_op(32'hFF00FF00, 32'h0FF00FF0, 12'h200, 64'hFFF0FFF0, "or");
        alu_op(32'd5, 32'd3, 12'h003, 64'h0, "multi_hot");
        alu_op(32'd5, 32'd3, 12'h000, 64'h0, "no_op");
    endtask

    task automatic test_random_add();
        logic [31:0] a, b, s;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            s = a + b;
            alu_op(a, b, 12'h001, {32'h0, s}, "rand_add");
        end
    endtask

    task automatic test_bus_priority();
        load_reg(1, 32'd5);
        load_reg(3, 32'd9);
        rout[1] = 1; rout[3] = 1;
        #1;
        checks++;
        if (bus !== 32'd5) begin
            errors++;
            $display("FAIL prio_r1_r3: got %h expected 00000005", bus);
        end
        mdr_read = 0; mdr_in = 1;
        exp_q.push_back(64'd5);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if ({32'h0, mdrq} !== e) begin
            errors++;
            $display("FAIL mdr_from_bus: got %h expected %h", mdrq, e[31:0]);
        end
        rout[3] = 1; hi_in = 1;
        tick();
        idle();
        hi_out = 1; lo_out = 1; mdr_out = 1;
        #1;
        checks++;
        if (bus !== 32'd9) begin
            errors++;
            $display("FAIL prio_hi_over_lo: got %h expected 00000009", bus);
        end
        idle();
        c_out = 1; pc_out = 1; inp_out = 1;
        #1;
        checks++;
        if ({bus, pcq, inq, cq} !== 128'h0) begin
            errors++;
            $display("FAIL const_sources: got %h %h %h %h expected zeros", bus, pcq, inq, cq);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        put_mdr(32'hA5A5A5A5);
        mdr_out = 1; rin[6] = 1; rin[7] = 1; lo_in = 1;
        tick();
        idle();
        checks++;
        if ({rq[6], rq[7], loq} !== {3{32'hA5A5A5A5}}) begin
            errors++;
            $display("FAIL multi_load: got %h %h %h expected a5a5a5a5 x3", rq[6], rq[7], loq);
        end
        load_reg(8, 32'h11);
        rout[6] = 1; rin[6] = 1; rin[8] = 1;
        tick();
        rout = '0; rin = '0;
        rout[8] = 1; rin[9] = 1;
        tick();
        idle();
        checks++;
        if ({rq[6], rq[8], rq[9]} !== {3{32'hA5A5A5A5}}) begin
            errors++;
            $display("FAIL self_and_chain: got %h %h %h expected a5a5a5a5 x3", rq[6], rq[8], rq[9]);
        end
    endtask

    task automatic test_async_reset();
        load_reg(7, 32'h77);
        @(negedge clk);
        #2;
        mdatain = 32'h55; mdr_read = 1; mdr_in = 1; rout[7] = 1; y_in = 1;
        clr = 1'b0;
        #1;
        checks++;
        if ({rq[7], mdrq, yq, zlq, hiq} !== 160'h0) begin
            errors++;
            $display("FAIL async_clear: got %h %h %h %h %h expected zeros", rq[7], mdrq, yq, zlq, hiq);
        end
        tick();
        idle();
        clr = 1'b1;
        load_reg(7, 32'h1234);
        checks++;
        if (rq[7] !== 32'h1234) begin
            errors++;
            $display("FAIL after_reset_load: got %h expected 00001234", rq[7]);
        end
    endtask

    initial begin
        idle();
        mdatain = '0;
        test_reset();
        test_mdr_load();
        test_shl();
        test_alu_ops();
        test_random_add();
        test_bus_priority();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
